// File: rtl/mole_round_scheduler.sv
// rtl/mole_round_scheduler.sv - whack-a-mole round sequencer: countdown, mole up/down pacing, difficulty ramp, game over
module mole_round_scheduler #(
  parameter int CLKS_PER_MS     = 50000,
  parameter int COUNTDOWN_MS    = 3000,
  parameter int MOLE_UP_MS      = 2000,
  parameter int MOLE_DOWN_MS    = 1000,
  parameter int MIN_UP_MS       = 500,
  parameter int RAMP_STEP_MS    = 100,
  parameter int ROUNDS_PER_STEP = 4,
  parameter int MAX_TIMER_MS    = 20000
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              start_button_pressed,
  input  logic [$clog2(MAX_TIMER_MS)-1:0]   timer_milliseconds,
  input  logic                              full_clear_hit,
  output logic                              game_in_progress,
  output logic                              mole_clk,
  output logic                              moles_visible,
  output logic                              countdown_active,
  output logic                              game_over,
  output logic [7:0]                        round_count,
  output logic [$clog2(MOLE_UP_MS+1)-1:0]   up_time_ms
);

  localparam int TW = $clog2(MAX_TIMER_MS);
  localparam int UW = $clog2(MOLE_UP_MS + 1);
  localparam int PW = (CLKS_PER_MS > 1) ? $clog2(CLKS_PER_MS) : 1;
  localparam int PH_MAX0 = (COUNTDOWN_MS > MOLE_UP_MS) ? COUNTDOWN_MS : MOLE_UP_MS;
  localparam int PH_MAX = (PH_MAX0 > MOLE_DOWN_MS) ? PH_MAX0 : MOLE_DOWN_MS;
  localparam int HW = $clog2(PH_MAX + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_COUNTDOWN, S_MOLE_UP, S_MOLE_DOWN, S_GAME_OVER
  } state_t;

  state_t state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [HW-1:0] phase_q, phase_d;
  logic [7:0]    round_q, round_d;
  logic [UW-1:0] up_q, up_d;
  logic          gip_q, gip_d;
  logic          mole_clk_q, mole_clk_d;
  logic          mv_q, mv_d;
  logic          cd_q, cd_d;
  logic          go_q, go_d;

  logic          ms_tick;
  logic [HW-1:0] phase_limit;
  logic          phase_done;
  logic          timer_zero;
  logic          entering;
  logic          mole_entry;
  logic [UW:0]   up_dec;
  logic [UW-1:0] up_ramped;
  logic          ramp_due;

  assign ms_tick    = (presc_q == PW'(CLKS_PER_MS - 1));
  assign timer_zero = (timer_milliseconds == TW'(0));

  // Extra headroom bit catches a borrow so the window clamps instead of wrapping.
  assign up_dec    = {1'b0, up_q} - (UW+1)'(RAMP_STEP_MS);
  assign up_ramped = (up_dec[UW] || (up_dec[UW-1:0] < UW'(MIN_UP_MS))) ? UW'(MIN_UP_MS)
                                                                       : up_dec[UW-1:0];
  assign ramp_due  = (round_q != 8'd0) &&
                     ((32'(round_q) % 32'(ROUNDS_PER_STEP)) == 32'd0);

  always_comb begin
    phase_limit = HW'(0);
    case (state_q)
      S_COUNTDOWN: phase_limit = HW'(COUNTDOWN_MS);
      S_MOLE_UP:   phase_limit = HW'(up_q);
      S_MOLE_DOWN: phase_limit = HW'(MOLE_DOWN_MS);
      default:     phase_limit = HW'(0);
    endcase
  end

  assign phase_done = ms_tick && (phase_q == (phase_limit - HW'(1)));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      presc_q    <= '0;
      phase_q    <= '0;
      round_q    <= 8'd0;
      up_q       <= UW'(MOLE_UP_MS);
      gip_q      <= 1'b0;
      mole_clk_q <= 1'b0;
      mv_q       <= 1'b0;
      cd_q       <= 1'b0;
      go_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      presc_q    <= presc_d;
      phase_q    <= phase_d;
      round_q    <= round_d;
      up_q       <= up_d;
      gip_q      <= gip_d;
      mole_clk_q <= mole_clk_d;
      mv_q       <= mv_d;
      cd_q       <= cd_d;
      go_q       <= go_d;
    end
  end

  // Timer expiry is checked first so it beats a same-cycle clear or phase expiry.
  always_comb begin
    state_d = state_q;
    up_d    = up_q;
    case (state_q)
      S_IDLE:      if (start_button_pressed) state_d = S_COUNTDOWN;
      S_COUNTDOWN: if (phase_done) state_d = S_MOLE_UP;
      S_MOLE_UP: begin
        if (timer_zero) begin
          state_d = S_GAME_OVER;
        end else if (full_clear_hit || phase_done) begin
          state_d = S_MOLE_DOWN;
          if (ramp_due) up_d = up_ramped;
        end
      end
      S_MOLE_DOWN: begin
        if (timer_zero) state_d = S_GAME_OVER;
        else if (phase_done) state_d = S_MOLE_UP;
      end
      S_GAME_OVER: state_d = S_GAME_OVER;
      default:     state_d = S_IDLE;
    endcase

    entering   = (state_d != state_q);
    mole_entry = (state_d == S_MOLE_UP) && (state_q != S_MOLE_UP);

    if (entering || ms_tick) presc_d = '0;
    else                     presc_d = presc_q + PW'(1);

    if (entering)
      phase_d = '0;
    else if (ms_tick && (state_q inside {S_COUNTDOWN, S_MOLE_UP, S_MOLE_DOWN}))
      phase_d = phase_q + HW'(1);
    else
      phase_d = phase_q;

    if (mole_entry && (round_q != 8'hFF)) round_d = round_q + 8'd1;
    else                                   round_d = round_q;
  end

  always_comb begin
    gip_d      = (state_d == S_MOLE_UP) || (state_d == S_MOLE_DOWN);
    mole_clk_d = mole_entry;
    mv_d       = (state_d == S_MOLE_UP);
    cd_d       = (state_d == S_COUNTDOWN);
    go_d       = (state_d == S_GAME_OVER);
  end

  assign game_in_progress = gip_q;
  assign mole_clk         = mole_clk_q;
  assign moles_visible    = mv_q;
  assign countdown_active = cd_q;
  assign game_over        = go_q;
  assign round_count      = round_q;
  assign up_time_ms       = up_q;

endmodule

// File: tb/tb_mole_round_scheduler.sv
// tb/tb_mole_round_scheduler.sv - directed self-checking bench for mole_round_scheduler
module tb_mole_round_scheduler;

  localparam int TW = $clog2(20000);

  logic          clk = 1'b0;
  logic          rst;
  logic          start_button_pressed;
  logic [TW-1:0] timer_milliseconds;
  logic          full_clear_hit;
  logic          game_in_progress;
  logic          mole_clk;
  logic          moles_visible;
  logic          countdown_active;
  logic          game_over;
  logic [7:0]    round_count;
  logic [2:0]    up_time_ms;

  int n_cmp = 0;
  int n_err = 0;
  int n_mclk = 0;
  int snap;
  int exp_up [8] = '{5, 5, 4, 4, 3, 3, 3, 3};

  mole_round_scheduler #(
    .CLKS_PER_MS(4), .COUNTDOWN_MS(3), .MOLE_UP_MS(5), .MOLE_DOWN_MS(2),
    .MIN_UP_MS(3), .RAMP_STEP_MS(1), .ROUNDS_PER_STEP(2), .MAX_TIMER_MS(20000)
  ) dut (
    .clk(clk), .rst(rst), .start_button_pressed(start_button_pressed),
    .timer_milliseconds(timer_milliseconds), .full_clear_hit(full_clear_hit),
    .game_in_progress(game_in_progress), .mole_clk(mole_clk),
    .moles_visible(moles_visible), .countdown_active(countdown_active),
    .game_over(game_over), .round_count(round_count), .up_time_ms(up_time_ms)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (mole_clk === 1'b1) n_mclk++;

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic tick_start();
    start_button_pressed = 1'b1;
    tick(1);
    start_button_pressed = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_gip"}, game_in_progress, 0);
    chk({tag, "_mclk"}, mole_clk, 0);
    chk({tag, "_mv"}, moles_visible, 0);
    chk({tag, "_cd"}, countdown_active, 0);
    chk({tag, "_go"}, game_over, 0);
    chk({tag, "_round"}, round_count, 0);
    chk({tag, "_up"}, up_time_ms, 5);
  endtask

  initial begin
    rst = 1'b1;
    start_button_pressed = 1'b0;
    timer_milliseconds = TW'(100);
    full_clear_hit = 1'b0;
    tick(2);
    chk_reset_outputs("reset");
    rst = 1'b0;

    // Scenario 1 with stray starts in COUNTDOWN and MOLE_DOWN
    tick(3);
    tick_start();
    chk("cd_first", countdown_active, 1);
    chk("cd_first_gip", game_in_progress, 0);
    tick(4);
    tick_start();
    tick(6);
    chk("cd_last", countdown_active, 1);
    chk("cd_last_mclk", mole_clk, 0);
    tick(1);
    chk("r1_mclk", mole_clk, 1);
    chk("r1_mv", moles_visible, 1);
    chk("r1_cd", countdown_active, 0);
    chk("r1_gip", game_in_progress, 1);
    chk("r1_round", round_count, 1);
    chk("r1_up", up_time_ms, 5);
    tick(1);
    chk("r1_mclk_single", mole_clk, 0);
    tick(18);
    chk("r1_mv_last", moles_visible, 1);
    tick(1);
    chk("r1_down_mv", moles_visible, 0);
    chk("r1_down_gip", game_in_progress, 1);
    tick(2);
    tick_start();
    tick(4);
    chk("r1_down_last_mclk", mole_clk, 0);
    chk("r1_down_round", round_count, 1);
    tick(1);
    chk("r2_mclk", mole_clk, 1);
    chk("r2_round", round_count, 2);
    chk("r2_up", up_time_ms, 5);

    // Scenario 2: ramp across rounds 2..8
    for (int k = 2; k <= 7; k++) begin
      tick(exp_up[k-1] * 4 + 7);
      chk($sformatf("ramp_pre_mclk_r%0d", k + 1), mole_clk, 0);
      tick(1);
      chk($sformatf("ramp_mclk_r%0d", k + 1), mole_clk, 1);
      chk($sformatf("ramp_up_r%0d", k + 1), up_time_ms, exp_up[k]);
      chk($sformatf("ramp_round_r%0d", k + 1), round_count, k + 1);
    end

    // Scenario 3: early advance in round 8
    tick(6);
    full_clear_hit = 1'b1;
    tick(1);
    full_clear_hit = 1'b0;
    chk("clear_mv", moles_visible, 0);
    chk("clear_gip", game_in_progress, 1);
    tick(7);
    chk("clear_down_last", mole_clk, 0);
    tick(1);
    chk("clear_mclk", mole_clk, 1);
    chk("clear_round", round_count, 9);
    chk("clear_up_floor", up_time_ms, 3);

    // Scenario 5: reset mid-MOLE_UP together with start
    tick(3);
    rst = 1'b1;
    start_button_pressed = 1'b1;
    tick(1);
    rst = 1'b0;
    start_button_pressed = 1'b0;
    chk_reset_outputs("rst_mid");
    tick(3);
    chk("idle_hold_cd", countdown_active, 0);
    tick_start();
    chk("restart_cd", countdown_active, 1);
    tick(11);
    chk("restart_cd_last", countdown_active, 1);
    tick(1);
    chk("restart_mclk", mole_clk, 1);
    chk("restart_round", round_count, 1);

    // Scenario 4a: timer expiry in MOLE_DOWN
    tick(22);
    chk("t0_down_state", moles_visible, 0);
    timer_milliseconds = TW'(0);
    tick(1);
    timer_milliseconds = TW'(100);
    chk("t0_down_go", game_over, 1);
    chk("t0_down_gip", game_in_progress, 0);
    snap = n_mclk;
    tick_start();
    tick(40);
    chk("t0_down_go_hold", game_over, 1);
    chk("t0_down_cd", countdown_active, 0);
    chk("t0_down_no_mclk", n_mclk, snap);

    // Scenario 4b: timer expiry in MOLE_UP with simultaneous full clear
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    tick_start();
    tick(12);
    chk("t0_up_mclk", mole_clk, 1);
    tick(4);
    timer_milliseconds = TW'(0);
    full_clear_hit = 1'b1;
    tick(1);
    timer_milliseconds = TW'(100);
    full_clear_hit = 1'b0;
    chk("t0_up_go", game_over, 1);
    chk("t0_up_gip", game_in_progress, 0);
    chk("t0_up_mv", moles_visible, 0);
    snap = n_mclk;
    tick_start();
    tick(40);
    chk("t0_up_go_hold", game_over, 1);
    chk("t0_up_no_mclk", n_mclk, snap);
    chk("t0_up_round", round_count, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
